// File: rtl/note_detector.sv
// Measures the period of a square-wave tone and resolves it to one of the 36 piano notes C3..B5.
// Optional feature macro: NOTE_DETECT_CONFIRM_EN (require CONFIRM identical matches before publishing).
module note_detector #(
    parameter int CLK_PER_US = 50,
    parameter int TIMEOUT_US = 10000,
    parameter int TOL_SHIFT  = 5,
    parameter int CONFIRM    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic        note_valid,
    output logic        note_err,
    output logic        note_active,
    output logic [5:0]  note_idx,
    output logic [35:0] note_onehot,
    output logic [13:0] period_us
);

    localparam int          PS_W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [13:0] TIMEOUT = 14'(TIMEOUT_US);

    if (CONFIRM < 1 || CONFIRM > 3) begin : g_bad_confirm
        $error("CONFIRM must be in 1..3");
    end

    typedef enum logic [1:0] {IDLE, MEASURE, SEARCH, CHECK} state_t;

    // Full tone period in us for each key, twice the generator's half-period table
    function automatic logic [13:0] ref_period(input logic [5:0] k);
        case (k)
            6'd0:  ref_period = 14'd7644;  6'd1:  ref_period = 14'd7216;
            6'd2:  ref_period = 14'd6810;  6'd3:  ref_period = 14'd6428;
            6'd4:  ref_period = 14'd6068;  6'd5:  ref_period = 14'd5726;
            6'd6:  ref_period = 14'd5406;  6'd7:  ref_period = 14'd5102;
            6'd8:  ref_period = 14'd4816;  6'd9:  ref_period = 14'd4546;
            6'd10: ref_period = 14'd4290;  6'd11: ref_period = 14'd4050;
            6'd12: ref_period = 14'd3822;  6'd13: ref_period = 14'd3608;
            6'd14: ref_period = 14'd3406;  6'd15: ref_period = 14'd3214;
            6'd16: ref_period = 14'd3034;  6'd17: ref_period = 14'd2864;
            6'd18: ref_period = 14'd2702;  6'd19: ref_period = 14'd2552;
            6'd20: ref_period = 14'd2408;  6'd21: ref_period = 14'd2272;
            6'd22: ref_period = 14'd2146;  6'd23: ref_period = 14'd2024;
            6'd24: ref_period = 14'd1912;  6'd25: ref_period = 14'd1804;
            6'd26: ref_period = 14'd1702;  6'd27: ref_period = 14'd1608;
            6'd28: ref_period = 14'd1516;  6'd29: ref_period = 14'd1432;
            6'd30: ref_period = 14'd1352;  6'd31: ref_period = 14'd1276;
            6'd32: ref_period = 14'd1204;  6'd33: ref_period = 14'd1136;
            6'd34: ref_period = 14'd1072;  6'd35: ref_period = 14'd1012;
            default: ref_period = 14'd0;
        endcase
    endfunction

    function automatic logic [14:0] abs_diff(input logic [13:0] a, input logic [13:0] b);
        abs_diff = (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    logic            s1, s2, s3;
    logic            rise, tick;
    logic [PS_W-1:0] presc;
    logic [13:0]     per_cnt, per_now;
    state_t          state;
    logic [5:0]      k, best;
    logic [14:0]     best_err, err_k, tol;

    assign rise  = s2 & ~s3;
    assign tick  = (presc == PS_W'(CLK_PER_US - 1));
    // A tick landing on the capture cycle completes that microsecond, so it counts
    assign per_now = (tick && per_cnt < TIMEOUT) ? per_cnt + 14'd1 : per_cnt;
    assign err_k = abs_diff(period_us, ref_period(k));
    assign tol   = {1'b0, ref_period(best)} >> TOL_SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
            presc   <= '0;
            per_cnt <= '0;
        end else begin
            s1 <= tone_in; s2 <= s1; s3 <= s2;
            if (rise) begin
                presc   <= '0;
                per_cnt <= '0;
            end else begin
                presc <= tick ? '0 : presc + PS_W'(1);
                if (tick && per_cnt < TIMEOUT) per_cnt <= per_cnt + 14'd1;
            end
        end
    end

`ifdef NOTE_DETECT_CONFIRM_EN
    logic [1:0] confirm_cnt, confirm_next;
    logic [5:0] last_idx;
    always_comb begin
        confirm_next = 2'd1;
        if (best == last_idx && confirm_cnt != 2'd0)
            confirm_next = (confirm_cnt == 2'd3) ? 2'd3 : confirm_cnt + 2'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            best        <= '0;
            best_err    <= '1;
            note_valid  <= 1'b0;
            note_err    <= 1'b0;
            note_active <= 1'b0;
            note_idx    <= '0;
            note_onehot <= '0;
            period_us   <= '0;
`ifdef NOTE_DETECT_CONFIRM_EN
            confirm_cnt <= '0;
            last_idx    <= '0;
`endif
        end else begin
            note_valid <= 1'b0;
            note_err   <= 1'b0;
            case (state)
                IDLE: if (rise) state <= MEASURE;
                MEASURE: begin
                    if (rise) begin
                        period_us <= per_now;
                        k         <= '0;
                        best      <= '0;
                        best_err  <= '1;
                        state     <= SEARCH;
                    end else if (per_cnt == TIMEOUT) begin
                        state       <= IDLE;
                        note_active <= 1'b0;
                        note_onehot <= '0;
`ifdef NOTE_DETECT_CONFIRM_EN
                        confirm_cnt <= '0;
`endif
                    end
                end
                SEARCH: begin
                    // Strict compare keeps the lower index on ties
                    if (err_k < best_err) begin
                        best     <= k;
                        best_err <= err_k;
                    end
                    if (k == 6'd35) state <= CHECK;
                    else            k <= k + 6'd1;
                end
                CHECK: begin
                    state <= MEASURE;
                    if (best_err <= tol) begin
`ifdef NOTE_DETECT_CONFIRM_EN
                        confirm_cnt <= confirm_next;
                        last_idx    <= best;
                        if (int'(confirm_next) >= CONFIRM) begin
                            note_valid  <= 1'b1;
                            note_idx    <= best;
                            note_onehot <= 36'd1 << best;
                            note_active <= 1'b1;
                        end
`else
                        note_valid  <= 1'b1;
                        note_idx    <= best;
                        note_onehot <= 36'd1 << best;
                        note_active <= 1'b1;
`endif
                    end else begin
                        note_err    <= 1'b1;
                        note_active <= 1'b0;
                        note_onehot <= '0;
`ifdef NOTE_DETECT_CONFIRM_EN
                        confirm_cnt <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector; prescaler shortened to 2 clk per us to keep the run short.
module tb_note_detector;

    localparam int CK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tone_in = 1'b0;
    logic        note_valid, note_err, note_active;
    logic [5:0]  note_idx;
    logic [35:0] note_onehot;
    logic [13:0] period_us;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;
    int err_cnt  = 0;

    note_detector #(.CLK_PER_US(CK)) dut (
        .clk(clk), .rst(rst), .tone_in(tone_in),
        .note_valid(note_valid), .note_err(note_err), .note_active(note_active),
        .note_idx(note_idx), .note_onehot(note_onehot), .period_us(period_us)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_valid) vld_cnt++;
        if (note_err)   err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full tone period of p us starting with a rising edge
    task automatic tone_period(input int p);
        tone_in = 1'b1;
        wait_cyc(p * CK / 2);
        tone_in = 1'b0;
        wait_cyc(p * CK - p * CK / 2);
    endtask

    task automatic clear_pulses;
        vld_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic check_lock(input string tag, input int idx, input int per);
        check({tag, "_valid"}, 64'(vld_cnt), 64'd1);
        check({tag, "_err"}, 64'(err_cnt), 64'd0);
        check({tag, "_idx"}, 64'(note_idx), 64'(idx));
        check({tag, "_onehot"}, 64'(note_onehot), 64'd1 << idx);
        check({tag, "_active"}, 64'(note_active), 64'd1);
        check({tag, "_period"}, 64'(period_us), 64'(per));
    endtask

    task automatic check_reject(input string tag, input int held_idx, input int per);
        check({tag, "_valid"}, 64'(vld_cnt), 64'd0);
        check({tag, "_err"}, 64'(err_cnt), 64'd1);
        check({tag, "_active"}, 64'(note_active), 64'd0);
        check({tag, "_onehot"}, 64'(note_onehot), 64'd0);
        check({tag, "_idx_held"}, 64'(note_idx), 64'(held_idx));
        check({tag, "_period"}, 64'(period_us), 64'(per));
    endtask

    initial begin
        // Reset with the input toggling
        @(negedge clk);
        clear_pulses();
        for (int i = 0; i < 2; i++) begin
            tone_in = ~tone_in;
            @(negedge clk);
        end
        check("rst_active", 64'(note_active), 64'd0);
        check("rst_idx", 64'(note_idx), 64'd0);
        check("rst_onehot", 64'(note_onehot), 64'd0);
        check("rst_period", 64'(period_us), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tone_in = ~tone_in;
            @(negedge clk);
        end
        check("rst_no_pulse", 64'(vld_cnt + err_cnt), 64'd0);
        tone_in = 1'b0;
        rst = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(4);

`ifdef NOTE_DETECT_CONFIRM_EN
        clear_pulses();
        tone_period(2272);
        tone_period(2272);
        tone_period(3822);
        tone_period(2272);
        tone_period(2272);
        tone_period(2272);
        check("cf_no_valid_yet", 64'(vld_cnt), 64'd0);
        check("cf_inactive_yet", 64'(note_active), 64'd0);
        tone_in = 1'b1;
        wait_cyc(100);
        check_lock("cf_a4", 21, 2272);
        tone_in = 1'b0;
        wait_cyc(2 * 10000 * CK / 2 + 100);
        check("cf_timeout_active", 64'(note_active), 64'd0);
`else
        tone_period(2272);
        clear_pulses(); tone_period(7644); check_lock("a4", 21, 2272);
        clear_pulses(); tone_period(1012); check_lock("c3", 0, 7644);
        clear_pulses(); tone_period(2200); check_lock("b5", 35, 1012);
        clear_pulses(); tone_period(9000); check_lock("a4s", 22, 2200);
        clear_pulses(); tone_period(900);  check_reject("rej_long", 22, 9000);
        clear_pulses(); tone_period(2272); check_reject("rej_short", 22, 900);

        // Final rise locks A4, then the input stays low until the timeout
        clear_pulses();
        tone_in = 1'b1;
        wait_cyc(100);
        check_lock("relock", 21, 2272);
        wait_cyc(2172);
        tone_in = 1'b0;
        wait_cyc(10000 * CK - 2272 - 20);
        check("pre_timeout_active", 64'(note_active), 64'd1);
        wait_cyc(60);
        check("timeout_active", 64'(note_active), 64'd0);
        check("timeout_onehot", 64'(note_onehot), 64'd0);
        check("timeout_no_pulse", 64'(vld_cnt + err_cnt), 64'd1);
`endif

        // Reset while the table search is running
        tone_period(1012);
        clear_pulses();
        tone_in = 1'b1;
        wait_cyc(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_active", 64'(note_active), 64'd0);
        check("midrst_idx", 64'(note_idx), 64'd0);
        check("midrst_onehot", 64'(note_onehot), 64'd0);
        check("midrst_period", 64'(period_us), 64'd0);
        wait_cyc(60);
        tone_in = 1'b0;
        check("midrst_no_pulse", 64'(vld_cnt + err_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
